// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word pipeline requests into word-wide memory accesses,
// using read-modify-write for sub-word stores and sign/zero extension for loads.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned MEM_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_error_o,
   output logic                  busy_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

   localparam logic [1:0] LatMax = 2'(MEM_LATENCY);

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic                  unsigned_q, unsigned_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            lat_cnt_q, lat_cnt_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_error_q, resp_error_d;

   logic                  req_bad;
   logic [4:0]            lane_sh;
   logic [DATA_WIDTH-1:0] rd_shifted, load_val, lane_mask, merged;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lat_cnt_q    <= 2'd0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lat_cnt_q    <= lat_cnt_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   assign req_bad = (req_size_i == 2'b11) ||
                    (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

   // Alignment is already checked, so shifting by the byte offset selects the lane.
   assign lane_sh    = {addr_q[1:0], 3'b000};
   assign rd_shifted = mem_rdata_i >> lane_sh;

   always_comb begin
      load_val  = mem_rdata_i;
      lane_mask = '0;
      merged    = wdata_q;
      unique case (size_q)
         2'b00: begin
            load_val  = {{(DATA_WIDTH-8){~unsigned_q & rd_shifted[7]}}, rd_shifted[7:0]};
            lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << lane_sh;
            merged    = (mem_rdata_i & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
         end
         2'b01: begin
            load_val  = {{(DATA_WIDTH-16){~unsigned_q & rd_shifted[15]}}, rd_shifted[15:0]};
            lane_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << lane_sh;
            merged    = (mem_rdata_i & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lat_cnt_d    = lat_cnt_q;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      req_ready_o  = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      mem_wdata_o  = '0;
      resp_valid_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               write_d    = req_write_i;
               size_d     = req_size_i;
               unsigned_d = req_unsigned_i;
               addr_d     = req_addr_i;
               wdata_d    = req_wdata_i;
               lat_cnt_d  = 2'd0;
               if (req_bad) begin
                  resp_rdata_d = '0;
                  resp_error_d = 1'b1;
                  state_d      = StResp;
               end else if (req_write_i && req_size_i == 2'b10) begin
                  state_d = StWr;
               end else begin
                  state_d = StRd;
               end
            end
         end
         StRd: begin
            mem_read_o = 1'b1;
            if (lat_cnt_q == LatMax) begin
               lat_cnt_d = 2'd0;
               if (write_q) begin
                  wdata_d = merged;
                  state_d = StWr;
               end else begin
                  resp_rdata_d = load_val;
                  resp_error_d = 1'b0;
                  state_d      = StResp;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end
         StWr: begin
            mem_write_o  = 1'b1;
            mem_wdata_o  = wdata_q;
            resp_rdata_d = '0;
            resp_error_d = 1'b0;
            state_d      = StResp;
         end
         StResp: begin
            resp_valid_o = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy_o       = (state_q != StIdle);
   assign mem_addr_o   = {2'b00, addr_q[ADDR_WIDTH-1:2]};
   assign resp_rdata_o = resp_rdata_q;
   assign resp_error_o = resp_error_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the EX/MEM pipeline register and the word-wide data memory. It accepts one memory request at a time from the pipeline and converts byte and halfword accesses into whole-word memory reads and writes. Sub-word stores use read-modify-write; loads return sign- or zero-extended data. It raises `busy` so the hazard unit can stall the pipeline while a request is in flight.

## Interface
- `DATA_WIDTH`, 32: data word width; only 32 is supported, giving 4 byte lanes.
- `ADDR_WIDTH`, 8: byte-address width of `req_addr` and width of `mem_addr`.
- `MEM_LATENCY`, 0: cycles from `mem_read` assertion to valid `mem_rdata`; legal range 0..3. 0 means a combinational read.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  zero-extend the load result; ignored for stores.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_error`  out  1  misaligned or illegal request; valid with `resp_valid`.
- `busy`  out  1  high whenever the state is not IDLE.
- `mem_read`  out  1  data-memory read enable.
- `mem_write`  out  1  data-memory write enable, sampled by memory on the rising edge.
- `mem_addr`  out  ADDR_WIDTH  word address, equal to `{2'b00, addr[ADDR_WIDTH-1:2]}`.
- `mem_wdata`  out  32  word to write; 0 outside WR.
- `mem_rdata`  in  32  word read from memory.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready` is 1. When `req_valid` is also 1, the unit latches write, size, unsigned, addr and wdata. The next state is:
  - RESP with error set, if size is 11, or size is half and addr[0] is 1, or size is word and addr[1:0] is not 0. No memory access is made.
  - RD, for a load.
  - WR, for a word store; the merged word is `req_wdata`.
  - RD, for a byte or half store.
- RD:
  - `mem_read` is 1 and `mem_addr` is held stable.
  - Counter `lat_cnt` starts at 0 and increments each cycle. On the cycle `lat_cnt == MEM_LATENCY`, the unit samples `mem_rdata` and leaves RD.
  - A load then goes to RESP with the extracted result. A store then goes to WR with the merged word.
- WR: `mem_write` is 1 for exactly one cycle, with `mem_wdata` set to the merged word. Next state is RESP.
- RESP: `resp_valid` is 1 for one cycle. `resp_rdata` and `resp_error` are held until the next RESP and cleared by reset. There is no back-pressure. Next state is IDLE.
- Lane mapping is little-endian:
  - Byte k (k = addr[1:0]) occupies bits [8k+7:8k].
  - Half h (h = addr[1]) occupies bits [16h+15:16h].
- Load extract: select the lane, then sign-extend from its MSB, or zero-extend if unsigned. A word load passes through unchanged.
- Store merge: replace only the addressed lane of the read word with the low byte or half of wdata; all other lanes keep their read value.
- A new request can be accepted only in IDLE, so back-to-back requests are separated by at least the RESP cycle.

## Timing
- Reset values: state IDLE, so `req_ready` is 1 and `busy` is 0. `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `resp_valid`, `resp_rdata`, `resp_error` and `lat_cnt` are all 0.
- Cycle counts below start with the acceptance edge as cycle 0 (L = `MEM_LATENCY`):
  - Error: `resp_valid` at cycle 1.
  - Word store: WR at cycle 1, `resp_valid` at cycle 2.
  - Load: RD at cycles 1..1+L, `resp_valid` at cycle 2+L.
  - Sub-word store: RD at cycles 1..1+L, WR at cycle 2+L, `resp_valid` at cycle 3+L.
- `mem_read` and `mem_write` are never asserted in the same cycle.
- Reset mid-operation aborts the request immediately, with no `resp_valid` and no later write. An asynchronous assertion during WR drops `mem_write` at once.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Word store 0xDEADBEEF to addr 0x04, then word load from 0x04, L=0: store `resp_valid` at cycle 2; load `resp_rdata` is 0xDEADBEEF at cycle 2; `resp_error` is 0 throughout.
- Byte loads from 0x07 after the word above: signed gives 0xFFFFFFDE; unsigned gives 0x000000DE. Repeat with L=2: `resp_valid` at cycle 4.
- Half store 0x1234 to addr 0x06: memory word 1 becomes 0x1234BEEF; the sequence is RD for 1 cycle, WR for 1 cycle, `resp_valid` at cycle 3; `mem_read` and `mem_write` never overlap.
- Error requests:
  - Half load at 0x05 gives `resp_error` 1 at cycle 1.
  - Word store at 0x02 gives `resp_error` 1 and no `mem_write` pulse.
  - Size 11 gives `resp_error` 1.
- `req_valid` held high for 3 word loads: each is accepted only when `req_ready` is 1; responses are in order, spaced 3 cycles apart (L=0).
- Assert `rst` during RD of a byte store: all outputs return to their reset values; `mem_write` never pulses; `req_ready` is 1 after `rst` deasserts.
